bcd3_to_bin_converter: RTL and testbench



---
 rtl/bcd3_to_bin_converter.sv | 79 +++++++
 tb/tb_bcd3_to_bin_converter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/bcd3_to_bin_converter.sv
// bcd3_to_bin_converter: sequential 3-digit BCD to binary converter using reverse double-dabble, one bit per clock
module bcd3_to_bin_converter #(
   parameter int OUTPUT_BIT_WIDTH = 10
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        start_i,
   input  logic [3:0]                  digit2_i,
   input  logic [3:0]                  digit1_i,
   input  logic [3:0]                  digit0_i,
   output logic [OUTPUT_BIT_WIDTH-1:0] output_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        error_o,
   output logic                        overflow_o
);
   typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_e;
   state_e      state_q;
   logic [11:0] bcd_q, bcd_d, shifted;
   logic [9:0]  res_q, res_d;
   logic [3:0]  cnt_q;
   logic        err_q, bad_digit;
   // one reverse double-dabble step: shift {bcd,res} right, then take 3 from every digit that lands at 8 or above
   always_comb begin
      shifted = bcd_q >> 1;
      res_d = {bcd_q[0], res_q[9:1]};
      bcd_d = '0;
      for (int i = 0; i < 3; i++)
         bcd_d[4*i +: 4] = shifted[4*i+3] ? shifted[4*i +: 4] - 4'd3 : shifted[4*i +: 4];
      bad_digit = (digit2_i > 4'd9) | (digit1_i > 4'd9) | (digit0_i > 4'd9);
   end
   // control FSM with registered outputs; result, error and overflow only change when leaving FINISH
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         bcd_q      <= '0;
         res_q      <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         output_o   <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         error_o    <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state_q)
            IDLE: if (start_i) begin
               busy_o <= 1'b1;
               err_q  <= bad_digit;
               if (bad_digit) state_q <= FINISH;
               else begin
                  bcd_q   <= {digit2_i, digit1_i, digit0_i};
                  res_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= CONVERT;
               end
            end
            CONVERT: begin
               bcd_q   <= bcd_d;
               res_q   <= res_d;
               cnt_q   <= cnt_q + 4'd1;
               state_q <= (cnt_q == 4'd9) ? FINISH : CONVERT;
            end
            FINISH: begin
               done_o  <= 1'b1;
               busy_o  <= 1'b0;
               error_o <= err_q;
               state_q <= IDLE;
               if (!err_q) begin
                  output_o   <= OUTPUT_BIT_WIDTH'(res_q);
                  overflow_o <= (res_q >> OUTPUT_BIT_WIDTH) != 10'd0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bcd3_to_bin_converter.sv
// tb_bcd3_to_bin_converter: table-driven and randomized check of the BCD-to-binary converter at widths 10 and 8
module tb_bcd3_to_bin_converter;
   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [3:0] d2 = '0, d1 = '0, d0 = '0;
   logic [9:0] out10;
   logic [7:0] out8;
   logic       busy10, done10, err10, ovf10, busy8, done8, err8, ovf8;
   int         vectors = 0, miscompares = 0;
   int         last_val = 0;
   bit         last_err = 1'b0;

   typedef struct {
      int a, b, c;
      int val;
      bit err;
      bit b2b;
      bit toggle;
   } vec_t;

   bcd3_to_bin_converter #(.OUTPUT_BIT_WIDTH(10)) dut10 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .digit2_i(d2), .digit1_i(d1), .digit0_i(d0),
      .output_o(out10), .busy_o(busy10), .done_o(done10), .error_o(err10), .overflow_o(ovf10));

   bcd3_to_bin_converter #(.OUTPUT_BIT_WIDTH(8)) dut8 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .digit2_i(d2), .digit1_i(d1), .digit0_i(d0),
      .output_o(out8), .busy_o(busy8), .done_o(done8), .error_o(err8), .overflow_o(ovf8));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic void ref_model(input int a, input int b, input int c, output int val, output bit err);
      err = (a > 9) || (b > 9) || (c > 9);
      val = a * 100 + b * 10 + c;
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, "_out10"}, out10, last_val);
      chk({tag, "_out8"}, out8, last_val % 256);
      chk({tag, "_err10"}, err10, last_err);
      chk({tag, "_err8"}, err8, last_err);
      chk({tag, "_ovf10"}, ovf10, 0);
      chk({tag, "_ovf8"}, ovf8, last_val > 255);
   endtask

   task automatic run(input int a, input int b, input int c, input int exp_val, input bit exp_err, input bit toggle);
      int n;
      bit busy_ok;
      d2 = 4'(a); d1 = 4'(b); d0 = 4'(c); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      busy_ok = 1'b1;
      while (!done10 && n < 20) begin
         if (!busy10 || !busy8) busy_ok = 1'b0;
         if (toggle) begin
            start = 1'($urandom_range(0, 1));
            d2 = 4'($urandom_range(0, 15));
            d1 = 4'($urandom_range(0, 15));
            d0 = 4'($urandom_range(0, 15));
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      if (!exp_err) last_val = exp_val;
      last_err = exp_err;
      chk("latency", n, exp_err ? 1 : 11);
      chk("busy_while_converting", busy_ok, 1);
      chk("busy_in_done_cycle", busy10, 0);
      chk("done8", done8, 1);
      check_outputs("result");
   endtask

   initial begin
      vec_t tbl[$];
      int   a, b, c, v;
      bit   e, saw;
      tbl.push_back('{9, 9, 9, 999, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{0, 0, 0, 0,   1'b0, 1'b0, 1'b0});
      tbl.push_back('{1, 2, 8, 128, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{2, 5, 5, 255, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{2, 5, 6, 256, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{0, 10, 3, 0,  1'b1, 1'b0, 1'b0});
      tbl.push_back('{0, 4, 2, 42,  1'b0, 1'b0, 1'b0});
      tbl.push_back('{15, 0, 0, 0,  1'b1, 1'b1, 1'b0});
      tbl.push_back('{5, 0, 0, 500, 1'b0, 1'b0, 1'b1});
      repeat (3) @(negedge clk);
      chk("reset_busy", busy10, 0);
      chk("reset_done", done10, 0);
      check_outputs("reset");
      rst_n = 1'b1;
      foreach (tbl[i]) begin
         if (!tbl[i].b2b) @(negedge clk);
         run(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].val, tbl[i].err, tbl[i].toggle);
      end
      @(negedge clk);
      d2 = 4'd7; d1 = 4'd7; d0 = 4'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      last_val = 0;
      last_err = 1'b0;
      chk("abort_busy", busy10, 0);
      chk("abort_done", done10, 0);
      check_outputs("abort");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      saw = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (done10 || done8) saw = 1'b1;
      end
      chk("no_done_after_abort", saw, 0);
      check_outputs("after_abort");
      @(negedge clk);
      run(0, 0, 1, 1, 1'b0, 1'b0);
      for (int k = 0; k < 40; k++) begin
         a = $urandom_range(0, 11);
         b = $urandom_range(0, 11);
         c = $urandom_range(0, 11);
         ref_model(a, b, c, v, e);
         if ($urandom_range(0, 1) == 0) @(negedge clk);
         run(a, b, c, v, e, 1'($urandom_range(0, 1)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
